// File: rtl/daq_event_packer_if.sv
// Detector-side event stream plus the show-ahead FIFO read port feeding the to-RAM DMA stage.
interface daq_event_packer_if #(
   parameter int FIFO_AW = 10
);
   logic              enable;
   logic              evt_start;
   logic [31:0]       evt_data;
   logic              evt_valid;
   logic              evt_last;
   logic              evt_ready;
   logic [31:0]       fifo_data_event;
   logic              fifo_data_empty;
   logic              fifo_data_ack;
   logic [FIFO_AW:0]  fifo_used;
   logic [31:0]       trig_count;
   logic [15:0]       busy_drop_cnt;

   // The environment: sample source, DMA consumer and status observer.
   modport master (
      output enable, evt_start, evt_data, evt_valid, evt_last, fifo_data_ack,
      input  evt_ready, fifo_data_event, fifo_data_empty, fifo_used,
             trig_count, busy_drop_cnt
   );

   // The packer itself.
   modport slave (
      input  enable, evt_start, evt_data, evt_valid, evt_last, fifo_data_ack,
      output evt_ready, fifo_data_event, fifo_data_empty, fifo_used,
             trig_count, busy_drop_cnt
   );
endinterface

// File: rtl/daq_event_packer.sv
// Frames detector events as header / trigger / payload / trailer and queues them in a
// show-ahead FIFO read directly by the HPS to-RAM DMA stage.
module daq_event_packer #(
   parameter int          FIFO_AW     = 10,
   parameter int          MAX_LEN     = 4095,
   parameter logic [31:0] HEADER_WORD = 32'hBABA1A9A,
   parameter logic [31:0] TRIG_INIT   = 32'h0
) (
   input logic              clk,
   input logic              reset,
   daq_event_packer_if.slave bus
);

   localparam int               DEPTH     = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_W   = (FIFO_AW + 1)'(DEPTH);
   localparam logic [15:0]      MAX_LEN_W = 16'(MAX_LEN);

   typedef enum logic [2:0] {IDLE, HDR, TRG, PAY, TRL} state_t;

   state_t               state;
   logic [31:0]          mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr;
   logic [FIFO_AW-1:0]   rd_ptr;
   logic [FIFO_AW:0]     used;
   logic [FIFO_AW:0]     used_nxt;
   logic [15:0]          len;
   logic [15:0]          len_acc;
   logic                 trunc;
   logic [31:0]          trig;
   logic [15:0]          drop_cnt;
   logic                 evt_ready_q;

   logic                 full;
   logic                 empty;
   logic                 discarding;
   logic                 accept;
   logic                 pop;
   logic                 wr_en;
   logic [31:0]          wr_data;

   assign full       = (used == DEPTH_W);
   assign empty      = (used == '0);
   assign discarding = (len >= MAX_LEN_W);
   assign accept     = (state == PAY) && bus.evt_valid && evt_ready_q;
   assign pop        = bus.fifo_data_ack && !empty;
   assign len_acc    = discarding ? len : len + 16'd1;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      wr_en   = 1'b0;
      wr_data = HEADER_WORD;
      unique case (state)
         HDR: wr_en = !full;
         TRG: begin
            wr_en   = !full;
            wr_data = trig;
         end
         PAY: begin
            wr_en   = accept && !discarding && !full;
            wr_data = bus.evt_data;
         end
         TRL: begin
            wr_en   = !full;
            wr_data = {4'hE, trunc, 11'h000, len};
         end
         default: ;
      endcase
   end

   always_comb begin
      unique case ({wr_en, pop})
         2'b10:   used_nxt = used + 1'b1;
         2'b01:   used_nxt = used - 1'b1;
         default: used_nxt = used;
      endcase
   end

   // NOTE: the storage array has no reset; the pointers and count define which words are live.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         used        <= '0;
         len         <= '0;
         trunc       <= 1'b0;
         trig        <= TRIG_INIT;
         drop_cnt    <= '0;
         evt_ready_q <= 1'b0;
      end else begin
         used <= used_nxt;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;

         if (bus.evt_start && (state != IDLE) && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;

         // evt_ready is registered, so it is computed from the post-edge count and length.
         unique case (state)
            IDLE: begin
               evt_ready_q <= 1'b0;
               if (bus.evt_start && bus.enable) begin
                  state <= HDR;
                  len   <= '0;
                  trunc <= 1'b0;
               end
            end
            HDR: if (!full) state <= TRG;
            TRG: begin
               if (!full) begin
                  trig        <= trig + 32'd1;
                  state       <= PAY;
                  evt_ready_q <= (used_nxt != DEPTH_W);
               end
            end
            PAY: begin
               if (accept) begin
                  len <= len_acc;
                  if (discarding) trunc <= 1'b1;
                  if (bus.evt_last) begin
                     state       <= TRL;
                     evt_ready_q <= 1'b0;
                  end else begin
                     evt_ready_q <= (used_nxt != DEPTH_W) || (len_acc >= MAX_LEN_W);
                  end
               end else begin
                  evt_ready_q <= (used_nxt != DEPTH_W) || discarding;
               end
            end
            TRL: if (!full) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.evt_ready       = evt_ready_q;
   assign bus.fifo_data_empty = empty;
   assign bus.fifo_data_event = empty ? 32'h0 : mem[rd_ptr];
   assign bus.fifo_used       = used;
   assign bus.trig_count      = trig;
   assign bus.busy_drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_daq_event_packer.sv
// Scoreboard bench for daq_event_packer: two instances (small FIFO, and truncating with wrapping
// trigger), expected words queued at stimulus time and compared by per-instance monitors.
module tb_daq_event_packer;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   daq_event_packer_if #(.FIFO_AW(2)) ifa ();
   daq_event_packer_if #(.FIFO_AW(4)) ifb ();

   daq_event_packer #(.FIFO_AW(2), .MAX_LEN(4), .TRIG_INIT(32'h0)) u_a (
      .clk(clk), .reset(rst_a), .bus(ifa));
   daq_event_packer #(.FIFO_AW(4), .MAX_LEN(2), .TRIG_INIT(32'hFFFFFFFF)) u_b (
      .clk(clk), .reset(rst_b), .bus(ifb));

   // Index 0 drives/observes instance A, index 1 instance B.
   logic        en_s    [2];
   logic        start_s [2];
   logic [31:0] data_s  [2];
   logic        valid_s [2];
   logic        last_s  [2];
   logic        ack_s   [2];
   logic        ready_s [2];
   logic        empty_s [2];
   logic [31:0] ev_s    [2];
   logic [31:0] used_s  [2];
   logic [31:0] trig_s  [2];
   logic [31:0] drop_s  [2];
   int          acc     [2];

   assign ifa.enable = en_s[0];  assign ifa.evt_start = start_s[0];
   assign ifa.evt_data = data_s[0];  assign ifa.evt_valid = valid_s[0];
   assign ifa.evt_last = last_s[0];  assign ifa.fifo_data_ack = ack_s[0];
   assign ifb.enable = en_s[1];  assign ifb.evt_start = start_s[1];
   assign ifb.evt_data = data_s[1];  assign ifb.evt_valid = valid_s[1];
   assign ifb.evt_last = last_s[1];  assign ifb.fifo_data_ack = ack_s[1];

   assign ready_s[0] = ifa.evt_ready;        assign ready_s[1] = ifb.evt_ready;
   assign empty_s[0] = ifa.fifo_data_empty;  assign empty_s[1] = ifb.fifo_data_empty;
   assign ev_s[0]    = ifa.fifo_data_event;  assign ev_s[1]    = ifb.fifo_data_event;
   assign used_s[0]  = 32'(ifa.fifo_used);   assign used_s[1]  = 32'(ifb.fifo_used);
   assign trig_s[0]  = ifa.trig_count;       assign trig_s[1]  = ifb.trig_count;
   assign drop_s[0]  = 32'(ifa.busy_drop_cnt); assign drop_s[1] = 32'(ifb.busy_drop_cnt);

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_a [$];
   logic [31:0] exp_b [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   task automatic push(input int d, input logic [31:0] w);
      if (d == 0) exp_a.push_back(w);
      else        exp_b.push_back(w);
   endtask

   function automatic int qsz(input int d);
      return (d == 0) ? exp_a.size() : exp_b.size();
   endfunction

   // Monitors: a pop happens at the next edge whenever ack is high on a non-empty FIFO.
   always @(negedge clk) begin
      if (!rst_a && ack_s[0] && !empty_s[0]) begin
         if (exp_a.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL a_extra_word: got %h expected none", ev_s[0]);
         end else begin
            check("a_word", ev_s[0], exp_a.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_b && ack_s[1] && !empty_s[1]) begin
         if (exp_b.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL b_extra_word: got %h expected none", ev_s[1]);
         end else begin
            check("b_word", ev_s[1], exp_b.pop_front());
         end
      end
   end

   task automatic pulse_start(input int d);
      start_s[d] = 1'b1;
      @(posedge clk); #1;
      start_s[d] = 1'b0;
   endtask

   task automatic send_word(input int d, input logic [31:0] w, input logic l);
      int n = 0;
      bit done = 1'b0;
      valid_s[d] = 1'b1; data_s[d] = w; last_s[d] = l;
      while (!done && n < 200) begin
         @(negedge clk);
         done = ready_s[d];
         @(posedge clk); #1;
         n++;
      end
      valid_s[d] = 1'b0; last_s[d] = 1'b0;
      if (done) acc[d]++;
      else begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: got no handshake expected one for %h", w);
      end
   endtask

   task automatic drain(input int d, input string name);
      int n = 0;
      while ((qsz(d) != 0 || !empty_s[d]) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_queue_left"}, 32'(qsz(d)), 32'd0);
      check({name, "_empty"}, 32'(empty_s[d]), 32'd1);
   endtask

   task automatic check_reset_state(input int d, input logic [31:0] trig_init, input string name);
      check({name, "_empty"}, 32'(empty_s[d]), 32'd1);
      check({name, "_event"}, ev_s[d], 32'd0);
      check({name, "_used"}, used_s[d], 32'd0);
      check({name, "_ready"}, 32'(ready_s[d]), 32'd0);
      check({name, "_trig"}, trig_s[d], trig_init);
      check({name, "_drop"}, drop_s[d], 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         en_s[i] = 1'b1; start_s[i] = 1'b0; data_s[i] = '0;
         valid_s[i] = 1'b0; last_s[i] = 1'b0; ack_s[i] = 1'b0; acc[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_state(0, 32'h0, "a_reset");
      check_reset_state(1, 32'hFFFFFFFF, "b_reset");
      rst_a = 1'b0; rst_b = 1'b0;
      @(posedge clk); #1;

      // A1: basic frame with ack held high.
      ack_s[0] = 1'b1;
      push(0, 32'hBABA1A9A); push(0, 32'h0);
      push(0, 32'h11); push(0, 32'h22); push(0, 32'h33); push(0, 32'hE0000003);
      pulse_start(0);
      send_word(0, 32'h11, 1'b0);
      send_word(0, 32'h22, 1'b0);
      send_word(0, 32'h33, 1'b1);
      drain(0, "a1");
      check("a1_trig", trig_s[0], 32'd1);

      // A2: fill the 4-word FIFO with no acks, then ack every other cycle.
      ack_s[0] = 1'b0;
      push(0, 32'hBABA1A9A); push(0, 32'h1);
      for (int i = 0; i < 4; i++) push(0, 32'hC0 + 32'(i));
      push(0, 32'hE0000004);
      pulse_start(0);
      fork
         begin
            for (int i = 0; i < 4; i++) send_word(0, 32'hC0 + 32'(i), i == 3);
         end
         begin
            int n = 0;
            @(negedge clk);
            while (used_s[0] != 32'd4 && n < 100) begin @(negedge clk); n++; end
            check("a2_full_used", used_s[0], 32'd4);
            check("a2_full_ready", 32'(ready_s[0]), 32'd0);
            @(posedge clk); #1; ack_s[0] = 1'b1;
            @(posedge clk); #1; ack_s[0] = 1'b0;
            @(negedge clk);
            check("a2_ack_full_no_write", used_s[0], 32'd3);
            n = 0;
            while (qsz(0) != 0 && n < 200) begin
               @(posedge clk); #1; ack_s[0] = 1'b1;
               @(posedge clk); #1; ack_s[0] = 1'b0;
               n++;
            end
         end
      join
      drain(0, "a2");
      check("a2_trig", trig_s[0], 32'd2);

      // A3: evt_start pulses during the payload phase are dropped and counted.
      ack_s[0] = 1'b1;
      push(0, 32'hBABA1A9A); push(0, 32'h2);
      push(0, 32'hA1); push(0, 32'hA2); push(0, 32'hE0000002);
      pulse_start(0);
      send_word(0, 32'hA1, 1'b0);
      pulse_start(0);
      pulse_start(0);
      send_word(0, 32'hA2, 1'b1);
      drain(0, "a3");
      check("a3_drop", drop_s[0], 32'd2);
      check("a3_trig", trig_s[0], 32'd3);

      // A4: reset in the middle of the payload discards the partial frame.
      ack_s[0] = 1'b0;
      pulse_start(0);
      send_word(0, 32'hD1, 1'b0);
      send_word(0, 32'hD2, 1'b0);
      check("a4_used_before_reset", used_s[0], 32'd4);
      #2 rst_a = 1'b1;
      #1;
      check_reset_state(0, 32'h0, "a4_reset");
      @(posedge clk); #1;
      rst_a = 1'b0;
      @(posedge clk); #1;
      ack_s[0] = 1'b1;
      push(0, 32'hBABA1A9A); push(0, 32'h0); push(0, 32'h77); push(0, 32'hE0000001);
      pulse_start(0);
      send_word(0, 32'h77, 1'b1);
      drain(0, "a4");
      check("a4_trig", trig_s[0], 32'd1);

      // B1: truncation at two stored words, trigger wrapping from FFFFFFFF.
      ack_s[1] = 1'b1;
      push(1, 32'hBABA1A9A); push(1, 32'hFFFFFFFF);
      push(1, 32'h1); push(1, 32'h2); push(1, 32'hE8000002);
      pulse_start(1);
      for (int i = 1; i <= 5; i++) send_word(1, 32'(i), i == 5);
      drain(1, "b1");
      check("b1_handshakes", 32'(acc[1]), 32'd5);
      check("b1_trig_wrap", trig_s[1], 32'd0);

      push(1, 32'hBABA1A9A); push(1, 32'h0); push(1, 32'h9); push(1, 32'hE0000001);
      pulse_start(1);
      send_word(1, 32'h9, 1'b1);
      drain(1, "b2");
      check("b2_trig", trig_s[1], 32'd1);

      // B3: evt_start with enable low is ignored and not counted.
      en_s[1] = 1'b0;
      pulse_start(1);
      repeat (5) @(posedge clk);
      #1;
      check("b3_used", used_s[1], 32'd0);
      check("b3_empty", 32'(empty_s[1]), 32'd1);
      check("b3_drop", drop_s[1], 32'd0);
      check("b3_trig", trig_s[1], 32'd1);
      check("b3_ready", 32'(ready_s[1]), 32'd0);

      check("a_final_queue", 32'(qsz(0)), 32'd0);
      check("b_final_queue", 32'(qsz(1)), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/daq_event_packer.md
Name: daq_event_packer

Overview:
- Builds framed events from the detector sample stream and buffers them in an internal show-ahead FIFO.
- Presents that FIFO directly to the HPS to-RAM DMA stage through three signals: `fifo_data_event`, `fifo_data_empty` and `fifo_data_ack`.
- Sits immediately upstream of the soc_system `to_ram_fifo_data_*` conduit. It is the producer of what that stage consumes.
- Frame format: header, trigger number, payload words, trailer carrying the length and status.

Parameters:
- FIFO_AW, 10, FIFO address width; depth = 2**FIFO_AW words.
- MAX_LEN, 4095, maximum payload words stored per event; excess words are discarded.
- HEADER_WORD, 32'hBABA1A9A, first word of every frame.
- TRIG_INIT, 32'h0, reset value of the trigger counter.

Ports:
- clk  in  1  system clock; all logic in this single domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  from `to_ram_ctrl_enable`; gates acceptance of new events.
- evt_start  in  1  one-cycle pulse requesting a new event.
- evt_data  in  32  payload word.
- evt_valid  in  1  `evt_data` is valid.
- evt_last  in  1  marks the final payload word, qualified by `evt_valid`.
- evt_ready  out  1  packer accepts the payload word this cycle.
- fifo_data_event  out  32  FIFO head word (show-ahead); drives `to_ram_fifo_data_event`.
- fifo_data_empty  out  1  FIFO empty; drives `to_ram_fifo_data_empty`.
- fifo_data_ack  in  1  pops the head word; driven by `to_ram_fifo_data_ack`.
- fifo_used  out  FIFO_AW+1  current word count.
- trig_count  out  32  trigger number of the next event.
- busy_drop_cnt  out  16  count of `evt_start` pulses ignored because an event was in progress.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, FIFO cleared.
  - `fifo_data_empty` = 1, `fifo_data_event` = 0, `fifo_used` = 0.
  - `evt_ready` = 0, `trig_count` = TRIG_INIT, `busy_drop_cnt` = 0.
  - A reset mid-event discards the partial frame. Nothing is ever emitted for it.
- FIFO write condition: a write occurs only when full == 0, where full means `fifo_used` == 2**FIFO_AW. Full is evaluated on the registered count.
  - A simultaneous ack while full does not free a slot for a write in the same cycle.
- FIFO read side (show-ahead):
  - `fifo_data_event` is valid whenever `fifo_data_empty` = 0.
  - `fifo_data_ack` high with empty = 0 pops the head; the next word appears the following cycle.
  - An ack while empty is ignored, and no state changes.
  - A word written to an empty FIFO appears with `fifo_data_empty` = 0 exactly one cycle after the write.
  - A write and an ack on an empty FIFO: the ack is ignored.
- `fifo_used` update: +1 on write only, -1 on pop only, unchanged when both occur.
- FSM states: IDLE, HDR, TRG, PAY, TRL.
  - IDLE: on `evt_start` && `enable` -> HDR. On `evt_start` && !`enable` -> ignored, not counted.
  - HDR: write HEADER_WORD when not full, then -> TRG. Stall while full.
  - TRG: write `trig_count`, then increment it (32-bit wrap FFFFFFFF->0), then -> PAY. Stall while full.
  - PAY: `evt_ready` = (!full || discarding).
    - A word is accepted on `evt_valid` && `evt_ready`.
    - Accepted words are written while len < MAX_LEN. Beyond that, discarding = 1, the words are consumed without writing, and the trunc flag is set.
    - An accepted word with `evt_last` -> TRL.
    - A zero-payload event is not supported; the first payload word may carry `evt_last`.
  - TRL: write {4'hE, trunc, 11'h000, len[15:0]} when not full, then -> IDLE. len counts stored words only.
- `evt_ready` = 0 in every state except PAY.
- `evt_start` in any state other than IDLE increments `busy_drop_cnt`, which saturates at FFFF.
- `enable` falling mid-event has no effect: the current frame completes normally.
- Minimum frame latency: the header is written the cycle after `evt_start`, and appears on `fifo_data_event` one cycle later.

Test Plan:
- Empty FIFO, `evt_start`, 3 words 0x11/0x22/0x33 with `evt_last` on the third, `fifo_data_ack` held high -> read sequence BABA1A9A, 00000000, 11, 22, 33, E0000003; `trig_count` = 1; `fifo_data_empty` returns to 1.
- FIFO_AW = 2, no acks, event of 4 words -> `evt_ready` drops once `fifo_used` = 4. Then ack one word per 2 cycles -> frame completes intact with trailer E0000004; ack while full produces no same-cycle write.
- MAX_LEN = 2, event of 5 words -> 5 handshakes accepted, 2 stored, trailer E8000002.
- `evt_start` pulsed during PAY twice -> `busy_drop_cnt` = 2, single frame output, `trig_count` incremented once.
- Reset asserted during PAY after 2 words -> `fifo_data_empty` = 1 immediately (asynchronous). Next event reads header, TRIG_INIT, payload, with no stale words.
- TRIG_INIT = FFFFFFFF, two events -> trigger words FFFFFFFF then 00000000. `evt_start` with `enable` = 0 -> no write, and `busy_drop_cnt` unchanged.
